// File: rtl/inst_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_loader_pkg
// Shared constants and types for the instruction ROM and its byte-stream
// loader. The constants mirror the SoC-wide defines the core uses, so the ROM
// and the fetch stage agree on widths and the meaning of enable/reset levels.
//
// Contents:
//   INST_ADDR_W / INST_W   fetch address and instruction widths
//   DEF_ADDR_WIDTH         default word-index width (1024 words, 4 KiB)
//   CHIP_ENABLE/DISABLE    rom_ce_i levels
//   RST_ENABLE             rst level that holds the loader in reset
//   ZERO_WORD / NOP_INST   all-zero word; NOP is sll $0,$0,0
//   ld_state_e             loader FSM states
//   shift_in_byte()        big-endian byte assembler step
// -----------------------------------------------------------------------------
package inst_rom_loader_pkg;

  localparam int unsigned INST_ADDR_W    = 32;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0000;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  // Bytes arrive most-significant first, so each new byte enters at the
  // bottom and earlier bytes move toward bits 31:24.
  function automatic logic [INST_W-1:0] shift_in_byte(
    input logic [INST_W-1:0] acc,
    input logic [7:0]        new_byte
  );
    return {acc[INST_W-9:0], new_byte};
  endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// -----------------------------------------------------------------------------
// inst_rom_mem
// Instruction word storage: one synchronous write port used by the loader and
// one asynchronous read port used by the fetch path. The array has no reset;
// its contents survive rst so a core reset does not force a reload.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable, word written on rising clk
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data, combinational from raddr
// -----------------------------------------------------------------------------
module inst_rom_mem
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [INST_W-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [INST_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
// Instruction memory answering the core's fetch port, plus a byte-stream
// loader that fills the array from a UART bridge or test source.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rom_ce_i     in   fetch chip enable
//   rom_addr_i   in   fetch byte address (PC)
//   rom_data_o   out  fetched word, combinational; NOP when masked
//   ld_start_i   in   start-load request, honoured only in IDLE
//   ld_len_i     in   words to load, captured with ld_start_i
//   ld_valid_i   in   ld_byte_i valid
//   ld_byte_i    in   load byte, big-endian within each word
//   ld_ready_o   out  loader accepts a byte this cycle
//   ld_busy_o    out  load in progress (LOAD or DONE)
//   ld_done_o    out  one-cycle pulse after the last word is written
//   ld_err_o     out  one-cycle pulse when a start request is rejected
//
// Loader states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LD_IDLE | waiting for ld_start_i; fetch port live
//   LD_LOAD | accepting bytes, writing one word per four bytes
//   LD_DONE | single cycle with ld_done_o high, then back to IDLE
// -----------------------------------------------------------------------------
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int                ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [INST_W-1:0] NOP_WORD   = NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  input  logic                   ld_start_i,
  input  logic [ADDR_WIDTH:0]    ld_len_i,
  input  logic                   ld_valid_i,
  input  logic [7:0]             ld_byte_i,
  output logic                   ld_ready_o,
  output logic                   ld_busy_o,
  output logic                   ld_done_o,
  output logic                   ld_err_o
);

  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

  ld_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [INST_W-1:0]       asm_q, asm_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic                    last_word;
  logic                    xfer;

  logic [ADDR_WIDTH-1:0]   fetch_idx;
  logic [INST_ADDR_W-1:0]  fetch_hi;
  logic                    fetch_ok;
  logic [INST_W-1:0]       mem_rdata;

  assign ld_ready_o = (state_q == LD_LOAD);
  assign ld_busy_o  = (state_q == LD_LOAD) || (state_q == LD_DONE);
  assign ld_done_o  = (state_q == LD_DONE);
  assign ld_err_o   = err_q;

  assign xfer      = ld_valid_i && ld_ready_o;
  assign last_word = ({1'b0, word_idx_q} == (len_q - ONE_L));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= LD_IDLE;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= ZERO_WORD;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    len_d      = len_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (ld_start_i) begin
          if (ld_len_i == '0) begin
            state_d = LD_DONE;
          end else if (ld_len_i > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            len_d      = ld_len_i;
            word_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = LD_LOAD;
          end
        end
      end

      LD_LOAD: begin
        if (xfer) begin
          asm_d      = shift_in_byte(asm_q, ld_byte_i);
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes a word: write the assembled value on this
          // same edge rather than waiting a cycle for asm_q to catch up.
          if (byte_cnt_q == 2'd3) begin
            mem_we     = 1'b1;
            word_idx_d = word_idx_q + 1'b1;
            if (last_word) begin
              state_d = LD_DONE;
            end
          end
        end
      end

      LD_DONE: begin
        state_d = LD_IDLE;
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // Fetch is combinational so the core's fetch register captures the word on
  // the same edge as the PC. Reads are masked while busy, which also removes
  // any read/write collision on the array.
  assign fetch_idx = rom_addr_i[ADDR_WIDTH+1:2];
  assign fetch_hi  = rom_addr_i >> (ADDR_WIDTH + 2);
  assign fetch_ok  = (rom_ce_i == CHIP_ENABLE) && !ld_busy_o &&
                     (fetch_hi == '0) && (rst != RST_ENABLE);

  assign rom_data_o = fetch_ok ? mem_rdata : NOP_WORD;

  inst_rom_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we && (rst != RST_ENABLE)),
    .waddr (word_idx_q),
    .wdata (asm_d),
    .raddr (fetch_idx),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
// Directed bench for inst_rom_loader with ADDR_WIDTH=10.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_start_i;
  logic [AW:0] ld_len_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        ld_busy_o;
  logic        ld_done_o;
  logic        ld_err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  fetch_vec_t fv [8];

  logic [7:0] bytes_a [8];
  logic [7:0] bytes_b [8];
  logic [7:0] bytes_c [6];
  logic [7:0] bytes_d [4];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld_done_o) done_cnt++;
  end

  inst_rom_loader #(
    .ADDR_WIDTH (AW),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_len_i   (ld_len_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_ready_o (ld_ready_o),
    .ld_busy_o  (ld_busy_o),
    .ld_done_o  (ld_done_o),
    .ld_err_o   (ld_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fetch_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    #1;
    check(name, rom_data_o, exp);
  endtask

  // Presents one byte for one cycle; ready must be high for it to transfer.
  task automatic send_byte(input logic [7:0] b);
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    #1;
    check("ready_in_load", {31'd0, ld_ready_o}, 32'd1);
    tick();
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'h00;
  endtask

  task automatic start_load(input logic [AW:0] len);
    ld_start_i = 1'b1;
    ld_len_i   = len;
    tick();
    ld_start_i = 1'b0;
    ld_len_i   = '0;
  endtask

  // Called right after the edge that wrote the last word.
  task automatic check_done_pulse(input string tag);
    check({tag, "_done_hi"},  {31'd0, ld_done_o},  32'd1);
    check({tag, "_busy_hi"},  {31'd0, ld_busy_o},  32'd1);
    check({tag, "_ready_lo"}, {31'd0, ld_ready_o}, 32'd0);
    fetch_check({tag, "_fetch_in_done"}, 32'h0, 32'h0);
    tick();
    check({tag, "_done_lo"},  {31'd0, ld_done_o},  32'd0);
    check({tag, "_busy_lo"},  {31'd0, ld_busy_o},  32'd0);
  endtask

  initial begin
    bytes_a = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
    bytes_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bytes_c = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    bytes_d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    fv[0] = '{ce: 1'b1, addr: 32'h0000_0000, exp: 32'h3401_0005};
    fv[1] = '{ce: 1'b1, addr: 32'h0000_0004, exp: 32'h2402_0007};
    fv[2] = '{ce: 1'b1, addr: 32'h0000_0006, exp: 32'h2402_0007};
    fv[3] = '{ce: 1'b1, addr: 32'h0000_0003, exp: 32'h3401_0005};
    fv[4] = '{ce: 1'b0, addr: 32'h0000_0000, exp: 32'h0000_0000};
    fv[5] = '{ce: 1'b1, addr: 32'h0000_1000, exp: 32'h0000_0000};
    fv[6] = '{ce: 1'b1, addr: 32'h0000_1004, exp: 32'h0000_0000};
    fv[7] = '{ce: 1'b1, addr: 32'h8000_0000, exp: 32'h0000_0000};

    rst        = 1'b1;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0;
    ld_start_i = 1'b0;
    ld_len_i   = '0;
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_fetch_nop", rom_data_o, 32'h0);
    rst = 1'b0;
    #1;
    check("reset_fetch0", rom_data_o, 32'h0);
    check("reset_ready",  {31'd0, ld_ready_o}, 32'd0);
    check("reset_busy",   {31'd0, ld_busy_o},  32'd0);
    check("reset_done",   {31'd0, ld_done_o},  32'd0);
    check("reset_err",    {31'd0, ld_err_o},   32'd0);

    // Two-word load, back-to-back bytes
    start_load(11'd2);
    check("a_busy", {31'd0, ld_busy_o}, 32'd1);
    fetch_check("a_fetch_busy", 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes_a[i]);
    end
    check_done_pulse("a");
    check("a_done_cnt", done_cnt, 1);

    for (int i = 0; i < 8; i++) begin
      rom_ce_i   = fv[i].ce;
      rom_addr_i = fv[i].addr;
      #1;
      check($sformatf("fetch_vec%0d", i), rom_data_o, fv[i].exp);
    end

    // Two-word load with idle gaps; a second start mid-load must be ignored
    start_load(11'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes_b[i]);
      if (i < 7) begin
        ld_start_i = (i == 1);
        ld_len_i   = 11'd1;
        #1;
        check($sformatf("b_ready_gap%0d", i), {31'd0, ld_ready_o}, 32'd1);
        tick();
        ld_start_i = 1'b0;
        ld_len_i   = '0;
      end
    end
    check_done_pulse("b");
    check("b_done_cnt", done_cnt, 2);
    fetch_check("b_word0", 32'h0, 32'h1122_3344);
    fetch_check("b_word1", 32'h4, 32'h5566_7788);

    // Oversized length rejected
    start_load(11'd1025);
    check("err_hi",    {31'd0, ld_err_o},   32'd1);
    check("err_busy",  {31'd0, ld_busy_o},  32'd0);
    check("err_ready", {31'd0, ld_ready_o}, 32'd0);
    tick();
    check("err_lo",    {31'd0, ld_err_o},   32'd0);
    check("err_done_cnt", done_cnt, 2);

    // Zero length: done pulse, no writes
    start_load(11'd0);
    check_done_pulse("z");
    check("z_done_cnt", done_cnt, 3);
    fetch_check("z_word0", 32'h0, 32'h1122_3344);

    // Full-depth length is legal; abort it with reset
    start_load(11'd1024);
    check("max_err",   {31'd0, ld_err_o},   32'd0);
    check("max_ready", {31'd0, ld_ready_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("max_abort_busy", {31'd0, ld_busy_o}, 32'd0);

    // Reset after six bytes of a two-word load
    start_load(11'd2);
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes_c[i]);
    end
    rst = 1'b1;
    tick();
    fetch_check("c_fetch_in_rst", 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("c_busy",  {31'd0, ld_busy_o}, 32'd0);
    fetch_check("c_word0", 32'h0, 32'hAABB_CCDD);
    fetch_check("c_word1", 32'h4, 32'h5566_7788);
    tick();
    check("c_done_cnt", done_cnt, 3);

    // A fresh load after the abort starts from a clean byte count
    start_load(11'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes_d[i]);
    end
    check_done_pulse("d");
    check("d_done_cnt", done_cnt, 4);
    fetch_check("d_word0", 32'h0, 32'hDEAD_BEEF);
    fetch_check("d_word1", 32'h4, 32'h5566_7788);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
